binario_bcd_serial: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm. It processes one input bit per clock cycle. It is the multi-cycle successor to the combinational 4-bit decoder and accepts any `BIN_W`-bit operand through valid/ready handshakes on both sides. It sits between arithmetic datapaths and display/UART formatting blocks.

---
 rtl/binario_bcd_pkg.sv | 29 ++
 rtl/binario_bcd_serial_add3.sv | 11 +
 rtl/binario_bcd_serial.sv | 133 +++++++++++++
 tb/tb_binario_bcd_serial.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/binario_bcd_pkg.sv
// Shared types and elaboration helpers for the serial binary-to-BCD converter.
package binario_bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // Smallest digit count whose decimal range covers every bin_w-bit value.
    function automatic int bcd_digits_min(input int bin_w);
        longint unsigned max_val;
        longint unsigned pow10;
        int              digits;
        max_val = (bin_w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bin_w) - 64'd1);
        pow10   = 64'd10;
        digits  = 1;
        for (int i = 0; i < 19; i++) begin
            if (pow10 <= max_val) begin
                pow10  = pow10 * 64'd10;
                digits = digits + 1;
            end
        end
        return digits;
    endfunction

endpackage

// File: rtl/binario_bcd_serial_add3.sv
// Single-digit add-3 correction cell used before each double-dabble shift.
module bcd_add3
    import binario_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/binario_bcd_serial.sv
// Serial shift-add-3 binary-to-BCD converter, one operand bit per clock.
// Optional two's-complement input when BINARIO_BCD_SIGNED_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | one adjust+shift per cycle, busy high
// DONE  | result held on bcd/neg with out_valid until out_ready
module binario_bcd_serial
    import binario_bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_W-1:0]          bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      neg,
    output logic                      busy
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 2) begin : g_bad_width
        $error("binario_bcd_serial: BIN_W must be at least 2");
    end
    if (DIGITS < bcd_digits_min(BIN_W)) begin : g_bad_digits
        $error("binario_bcd_serial: DIGITS too small to hold 2**BIN_W-1");
    end

    bcd_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] shreg;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_adj;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [BIN_W-1:0] load_mag;
    logic             load_neg;
    logic             unused_carry;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .digit    (acc[g*DIGIT_W +: DIGIT_W]),
            .adjusted (acc_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // With enough digits the top accumulator bit is always 0 when shifted out.
    assign unused_carry = acc_adj[BCD_W-1];

`ifdef BINARIO_BCD_SIGNED_EN
    logic neg_r;

    // The most negative operand negates to itself, which reads correctly as unsigned.
    assign load_neg = bin[BIN_W-1];
    assign load_mag = load_neg ? (~bin + BIN_W'(1)) : bin;
    assign neg      = neg_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            neg_r <= load_neg;
        end
    end
`else
    assign load_neg = 1'b0;
    assign load_mag = bin;
    assign neg      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            acc         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg      <= load_mag;
                        acc        <= '0;
                        cnt        <= CNT_W'(BIN_W);
                        state      <= SHIFT;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc   <= {acc_adj[BCD_W-2:0], shreg[BIN_W-1]};
                    shreg <= {shreg[BIN_W-2:0], 1'b0};
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= DONE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign bcd       = acc;

endmodule

// File: tb/tb_binario_bcd_serial.sv
// Directed bench for binario_bcd_serial (BIN_W=8, DIGITS=3); signed expectations when BINARIO_BCD_SIGNED_EN is defined.
module tb_binario_bcd_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
    logic        neg;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int lat;
    int seen;

    always #5 clk = ~clk;

    binario_bcd_serial #(.BIN_W(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .neg       (neg),
        .busy      (busy)
    );

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent decimal model: digits by division, not by shifting.
    function automatic logic [11:0] model_bcd(input int m);
        return {4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic int mag_of(input logic [7:0] v);
`ifdef BINARIO_BCD_SIGNED_EN
        return v[7] ? (256 - int'(v)) : int'(v);
`else
        return int'(v);
`endif
    endfunction

    function automatic logic neg_of(input logic [7:0] v);
`ifdef BINARIO_BCD_SIGNED_EN
        return v[7];
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk_b("in_ready_wait", in_ready, 1'b1);
    endtask

    task automatic accept(input logic [7:0] v);
        wait_ready();
        in_valid = 1'b1;
        bin      = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bin      = ~v;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!out_valid && l < 40) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic conv(input logic [7:0] v, input logic [11:0] exp_bcd, input logic exp_neg);
        int l;
        out_ready = 1'b1;
        accept(v);
        wait_done(l);
        chk_i("latency", l, 8);
        chk_d("bcd", bcd, exp_bcd);
        chk_b("neg", neg, exp_neg);
        @(posedge clk); #1;
        chk_b("in_ready_after_take", in_ready, 1'b1);
        chk_b("out_valid_after_take", out_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        bin       = 8'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_b("rst_in_ready", in_ready, 1'b1);
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_d("rst_bcd", bcd, 12'h000);
        chk_b("rst_neg", neg, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed directed vectors.
`ifdef BINARIO_BCD_SIGNED_EN
        conv(8'h80, 12'h128, 1'b1);
        conv(8'hFF, 12'h001, 1'b1);
        conv(8'h7F, 12'h127, 1'b0);
        conv(8'h00, 12'h000, 1'b0);
        conv(8'h9C, 12'h100, 1'b1);
`else
        conv(8'd0,   12'h000, 1'b0);
        conv(8'd255, 12'h255, 1'b0);
        conv(8'd1,   12'h001, 1'b0);
        conv(8'd10,  12'h010, 1'b0);
        conv(8'd99,  12'h099, 1'b0);
        conv(8'd100, 12'h100, 1'b0);
        conv(8'd128, 12'h128, 1'b0);
`endif

        // Back-pressure: result held while out_ready is low.
        out_ready = 1'b0;
        accept(8'd173);
        wait_done(lat);
        chk_i("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
`ifdef BINARIO_BCD_SIGNED_EN
            chk_d("bp_bcd", bcd, 12'h083);
            chk_b("bp_neg", neg, 1'b1);
`else
            chk_d("bp_bcd", bcd, 12'h173);
            chk_b("bp_neg", neg, 1'b0);
`endif
            chk_b("bp_in_ready", in_ready, 1'b0);
            chk_b("bp_out_valid", out_valid, 1'b1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_b("bp_release_in_ready", in_ready, 1'b1);
        chk_b("bp_release_out_valid", out_valid, 1'b0);

        // Reset in the middle of a conversion.
        accept(8'd99);
        repeat (3) @(posedge clk);
        #1;
        chk_b("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_b("mid_rst_in_ready", in_ready, 1'b1);
        chk_b("mid_rst_out_valid", out_valid, 1'b0);
        chk_b("mid_rst_busy", busy, 1'b0);
        chk_d("mid_rst_bcd", bcd, 12'h000);
        chk_b("mid_rst_neg", neg, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk_i("mid_rst_no_pulse", seen, 0);
        conv(8'd42, 12'h042, 1'b0);

        // in_valid during SHIFT is ignored.
        out_ready = 1'b1;
        accept(8'd200);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1;
        bin      = 8'd7;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
`ifdef BINARIO_BCD_SIGNED_EN
        chk_d("ign_bcd", bcd, 12'h056);
        chk_b("ign_neg", neg, 1'b1);
`else
        chk_d("ign_bcd", bcd, 12'h200);
        chk_b("ign_neg", neg, 1'b0);
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_b("ign_busy", busy, 1'b0);
        chk_b("ign_in_ready", in_ready, 1'b1);

        // in_valid raised while DONE completes is taken only in the next IDLE cycle.
        accept(8'd50);
        wait_done(lat);
        chk_d("coll_first_bcd", bcd, 12'h050);
        in_valid = 1'b1;
        bin      = 8'd7;
        @(posedge clk); #1;
        chk_b("coll_not_taken_busy", busy, 1'b0);
        chk_b("coll_idle_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_b("coll_taken_busy", busy, 1'b1);
        chk_b("coll_taken_in_ready", in_ready, 1'b0);
        wait_done(lat);
        chk_i("coll_latency", lat, 8);
        chk_d("coll_bcd", bcd, 12'h007);
        @(posedge clk); #1;

        // Full operand sweep against the decimal model.
        for (int v = 0; v < 256; v++) begin
            conv(8'(v), model_bcd(mag_of(8'(v))), neg_of(8'(v)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
